// File: rtl/probe_display_controller_if.sv
// probe_display_controller_if: control keys and probe words in, clock-enable, status and display out.
// Ports (master = board side, slave = controller): run, halt, step_n, page_n, channel_data ->
// cpu_enable, running, channel_sel, tick_count, hex_out <-
interface probe_display_controller_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
);
    localparam int SW = $clog2(CHANNELS);
    logic                      run;
    logic                      halt;
    logic                      step_n;
    logic                      page_n;
    logic [CHANNELS*WIDTH-1:0] channel_data;
    logic                      cpu_enable;
    logic                      running;
    logic [SW-1:0]             channel_sel;
    logic [31:0]               tick_count;
    logic [55:0]               hex_out;
    modport master (
        output run, halt, step_n, page_n, channel_data,
        input  cpu_enable, running, channel_sel, tick_count, hex_out
    );
    modport slave (
        input  run, halt, step_n, page_n, channel_data,
        output cpu_enable, running, channel_sel, tick_count, hex_out
    );
endinterface

// File: rtl/probe_display_controller.sv
// probe_display_controller: run/step processor clock-enable generator with paged hex probe display.
// Ports: clock, reset (synchronous, active-high); bus (slave) takes run/halt levels, raw active-low
// step/page keys and probe words; returns the enable pulse, run status, selected channel,
// enable count and eight active-low seven-segment digits.
module probe_display_controller #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int DIV      = 25000000,
    parameter int DEBOUNCE = 500000
) (
    input  logic                      clock,
    input  logic                      reset,
    probe_display_controller_if.slave bus
);
    localparam int SW = $clog2(CHANNELS);
    localparam int DW = $clog2(DIV);
    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [0:0] HALTED  = 1'b0;
    localparam logic [0:0] RUNNING = 1'b1;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // key index 0 = step, 1 = page
    logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]          acc_q, acc_d, last_q, last_d, press_q, press_d, fire;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic [0:0]          state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic                cpu_enable_q, cpu_enable_d;
    logic [31:0]         tick_count_q, tick_count_d;
    logic [SW-1:0]       channel_sel_q, channel_sel_d;
    logic [55:0]         hex_q, hex_d;
    logic [WIDTH-1:0]    word;
    logic                go, stop, tc;

    always_comb begin
        sync1_d = {bus.page_n, bus.step_n};
        sync2_d = sync1_q;
        for (int i = 0; i < 2; i++) begin
            fire[i]  = (sync2_q[i] != acc_q[i]) && (cnt_q[i] == CW'(DEBOUNCE - 1));
            cnt_d[i] = (sync2_q[i] == acc_q[i] || fire[i]) ? '0 : cnt_q[i] + 1'b1;
            acc_d[i] = fire[i] ? sync2_q[i] : acc_q[i];
        end
        // press = accepted level seen falling, one cycle after acceptance
        last_d  = acc_q;
        press_d = last_q & ~acc_q;
        go      = state_q == HALTED && bus.run && !bus.halt;
        stop    = state_q == RUNNING && (bus.halt || !bus.run);
        tc      = div_q == DW'(DIV - 1);
        state_d = go ? RUNNING : stop ? HALTED : state_q;
        div_d   = (state_q == HALTED || stop || tc) ? '0 : div_q + 1'b1;
        // a step press is dropped when the FSM leaves HALTED the same cycle; halt wins over terminal count
        cpu_enable_d  = state_q == HALTED ? press_q[0] && !go : tc && !stop;
        tick_count_d  = tick_count_q + 32'(cpu_enable_d);
        channel_sel_d = !press_q[1] ? channel_sel_q :
                        channel_sel_q == SW'(CHANNELS - 1) ? '0 : channel_sel_q + 1'b1;
        word = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (channel_sel_q == SW'(k)) word = bus.channel_data[k*WIDTH +: WIDTH];
        hex_d = '1;
        for (int d = 0; d < WIDTH/4; d++) hex_d[d*7 +: 7] = glyph(word[d*4 +: 4]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            acc_q        <= 2'b11;
            last_q       <= 2'b11;
            press_q      <= '0;
            cnt_q        <= '0;
            state_q      <= HALTED;
            div_q        <= '0;
            cpu_enable_q <= 1'b0;
            tick_count_q <= '0;
            channel_sel_q <= '0;
            hex_q        <= '1;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            acc_q        <= acc_d;
            last_q       <= last_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            div_q        <= div_d;
            cpu_enable_q <= cpu_enable_d;
            tick_count_q <= tick_count_d;
            channel_sel_q <= channel_sel_d;
            hex_q        <= hex_d;
        end
    end

    assign bus.cpu_enable  = cpu_enable_q;
    assign bus.running     = state_q == RUNNING;
    assign bus.channel_sel = channel_sel_q;
    assign bus.tick_count  = tick_count_q;
    assign bus.hex_out     = hex_q;
endmodule

// File: tb/tb_probe_display_controller.sv
// tb_probe_display_controller: scoreboard bench for probe_display_controller (CHANNELS=3, WIDTH=16, DIV=5, DEBOUNCE=4).
module tb_probe_display_controller;
    localparam int CH = 3, W = 16, DIV = 5, DB = 4;

    typedef struct { int cyc; logic [31:0] val; } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    ev_t pq[$];
    ev_t sq[$];
    logic [31:0] tick_exp = '0;
    logic [1:0] sel_exp = '0;
    logic [1:0] sel_prev = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    probe_display_controller_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
    probe_display_controller #(.CHANNELS(CH), .WIDTH(W), .DIV(DIV), .DEBOUNCE(DB)) dut (
        .clock(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [55:0] hexv(input logic [6:0] d3, d2, d1, d0);
        return {{4{7'h7F}}, d3, d2, d1, d0};
    endfunction

    // monitor: every enable pulse and channel change is matched against the queued expectation
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            while (pq.size() > 0 && pq[0].cyc < cyc) begin
                n_vec++; n_err++;
                $display("FAIL pulse_missing: no cpu_enable at cycle %0d (tick %0h expected)", pq[0].cyc, pq[0].val);
                e = pq.pop_front();
            end
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                n_vec++; n_err++;
                $display("FAIL sel_missing: channel_sel %0d not seen at cycle %0d", sq[0].val, sq[0].cyc);
                e = sq.pop_front();
            end
            if (bus.cpu_enable) begin
                if (pq.size() == 0 || pq[0].cyc != cyc) begin
                    n_vec++; n_err++;
                    $display("FAIL pulse_unexpected: cpu_enable=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = pq.pop_front();
                    chk("pulse_tick", 64'(bus.tick_count), 64'(e.val));
                end
            end
            if (bus.channel_sel != sel_prev) begin
                if (sq.size() == 0 || sq[0].cyc != cyc) begin
                    n_vec++; n_err++;
                    $display("FAIL sel_unexpected: channel_sel=%0d at cycle %0d", bus.channel_sel, cyc);
                end else begin
                    e = sq.pop_front();
                    chk("channel_sel", 64'(bus.channel_sel), 64'(e.val));
                end
            end
        end
        sel_prev = bus.channel_sel;
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // key held low from the next edge E: effect visible after edge E+DB+3
    task automatic press(input bit step, input bit page, input int hold, input bit step_acts);
        int e = cyc + 1;
        if (step) begin
            bus.step_n = 1'b0;
            if (step_acts) begin
                tick_exp = tick_exp + 1;
                pq.push_back('{e + DB + 3, tick_exp});
            end
        end
        if (page) begin
            bus.page_n = 1'b0;
            sel_exp = (sel_exp == 2'(CH - 1)) ? 2'd0 : sel_exp + 2'd1;
            sq.push_back('{e + DB + 3, 32'(sel_exp)});
        end
        repeat (hold) @(negedge clk);
        bus.step_n = 1'b1;
        bus.page_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_cpu_enable", 64'(bus.cpu_enable), 64'd0);
        chk("rst_running", 64'(bus.running), 64'd0);
        chk("rst_channel_sel", 64'(bus.channel_sel), 64'd0);
        chk("rst_tick_count", 64'(bus.tick_count), 64'd0);
        chk("rst_hex_out", 64'(bus.hex_out), 64'h00FF_FFFF_FFFF_FFFF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int t, e, r;
        int glitch [3] = '{1, 1, 3};
        bus.run = 1'b0;
        bus.halt = 1'b0;
        bus.step_n = 1'b1;
        bus.page_n = 1'b1;
        bus.channel_data = {16'hBCDE, 16'hA5F0, 16'h1234};
        repeat (2) @(negedge clk);
        chk_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("hex_ch0", 64'(bus.hex_out), 64'(hexv(7'h79, 7'h24, 7'h30, 7'h19)));

        // short glitches (including DB-1 cycles) are rejected, then a real held press
        foreach (glitch[i]) begin
            bus.step_n = 1'b0;
            repeat (glitch[i]) @(negedge clk);
            bus.step_n = 1'b1;
            repeat (8) @(negedge clk);
        end
        press(1, 0, 20, 1);
        chk("tick_after_step", 64'(bus.tick_count), 64'd1);

        // free run, step ignored while running, halt on a terminal cycle suppresses the pulse
        t = cyc + 1;
        bus.run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick_exp = tick_exp + 1;
            pq.push_back('{t + DIV*i, tick_exp});
        end
        @(negedge clk);
        chk("running_rise", 64'(bus.running), 64'd1);
        press(1, 0, 10, 0);
        wait_until(t + 5*DIV - 1);
        bus.halt = 1'b1;
        @(negedge clk);
        chk("running_fall", 64'(bus.running), 64'd0);
        bus.halt = 1'b0;
        bus.run = 1'b0;
        repeat (3) @(negedge clk);
        chk("tick_after_run", 64'(bus.tick_count), 64'(tick_exp));

        // step press on the same edge as HALTED->RUNNING is dropped
        e = cyc + 1;
        bus.step_n = 1'b0;
        wait_until(e + DB + 2);
        bus.run = 1'b1;
        tick_exp = tick_exp + 1;
        pq.push_back('{e + DB + 3 + DIV, tick_exp});
        wait_until(e + DB + 3 + DIV + 2);
        bus.run = 1'b0;
        repeat (3) @(negedge clk);
        bus.step_n = 1'b1;
        repeat (10) @(negedge clk);

        // paging and display
        press(0, 1, 8, 0);
        chk("hex_ch1", 64'(bus.hex_out), 64'(hexv(7'h08, 7'h12, 7'h0E, 7'h40)));
        bus.channel_data[31:16] = 16'h6789;
        @(negedge clk);
        chk("hex_data_change", 64'(bus.hex_out), 64'(hexv(7'h02, 7'h78, 7'h00, 7'h10)));
        press(0, 1, 8, 0);
        chk("hex_ch2", 64'(bus.hex_out), 64'(hexv(7'h03, 7'h46, 7'h21, 7'h06)));
        press(1, 1, 8, 1);
        chk("hex_wrap_ch0", 64'(bus.hex_out), 64'(hexv(7'h79, 7'h24, 7'h30, 7'h19)));

        // tick_count wrap
        force dut.tick_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.tick_count_q;
        tick_exp = 32'hFFFF_FFFF;
        press(1, 0, 8, 1);

        // reset mid-run and mid-debounce, key held through reset
        press(0, 1, 8, 0);
        t = cyc + 1;
        bus.run = 1'b1;
        tick_exp = tick_exp + 1;
        pq.push_back('{t + DIV, tick_exp});
        wait_until(t + DIV);
        bus.step_n = 1'b0;
        wait_until(t + DIV + 2);
        bus.run = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset();
        tick_exp = '0;
        sel_exp = '0;
        @(negedge clk);
        reset = 1'b0;
        r = cyc;
        // internal press at r+DB+3, enable visible one edge later
        tick_exp = tick_exp + 1;
        pq.push_back('{r + DB + 4, tick_exp});
        wait_until(r + DB + 8);
        bus.step_n = 1'b1;
        repeat (20) @(negedge clk);

        foreach (pq[i]) begin
            n_vec++; n_err++;
            $display("FAIL pulse_leftover: cycle %0d tick %0h", pq[i].cyc, pq[i].val);
        end
        foreach (sq[i]) begin
            n_vec++; n_err++;
            $display("FAIL sel_leftover: cycle %0d sel %0d", sq[i].cyc, sq[i].val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/probe_display_controller.md
# probe_display_controller

Parametrised run/step controller and hex probe display for the board-level processor wrapper. It generates a single-cycle processor clock enable (free-running divider or debounced single-step key), pages through CHANNELS probe words selected by a second key, and drives eight active-low seven-segment digits from the selected word. It replaces fixed divider gating and fixed per-group display wiring with one synchronous block on the 50 MHz board clock.

## Interface
- CHANNELS, 4: number of probe words; ≥2.
- WIDTH, 32: bits per probe word; multiple of 4, range 4..32.
- DIV, 25000000: clock cycles between run-mode enables; ≥2.
- DEBOUNCE, 500000: cycles a key must hold a new level before it is accepted; ≥2.
- clock  in  1  board clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 requests free-running mode.
- halt  in  1  level; 1 forces halted mode, overrides run.
- step_n  in  1  raw active-low key; a press issues one enable while halted.
- page_n  in  1  raw active-low key; a press advances channel_sel.
- channel_data  in  CHANNELS*WIDTH  probe words, channel k at [k*WIDTH +: WIDTH].
- cpu_enable  out  1  one-cycle processor clock-enable pulse.
- running  out  1  1 while in RUNNING state.
- channel_sel  out  $clog2(CHANNELS)  displayed channel.
- tick_count  out  32  number of cpu_enable pulses since reset.
- hex_out  out  56  digit d at [d*7 +: 7], d=0 least significant nibble; active-low gfedcba.

## Operation
- Keys: each passes a 2-flop synchroniser, then a debouncer. The counter increments while synchronised level ≠ accepted level and clears when they agree. When it reaches DEBOUNCE-1 with disagreement still present, the accepted level takes the new value and the counter clears. An accepted 1→0 transition produces a one-cycle press pulse.
- FSM states:
  - HALTED: run=1 and halt=0 → RUNNING, divider cleared. Otherwise a step press → cpu_enable=1 next cycle.
  - RUNNING: divider counts 0..DIV-1. At terminal count, cpu_enable pulses and the divider wraps to 0. halt=1 or run=0 → HALTED with divider cleared. Step presses are ignored.
- tick_count increments on every cpu_enable pulse and wraps 2^32-1→0.
- Page press: channel_sel ← (channel_sel+1) mod CHANNELS. Wraps CHANNELS-1→0, including non-power-of-2 CHANNELS.
- Display: digits 0..WIDTH/4-1 show the nibbles of the selected word. Digits ≥WIDTH/4 are blank (7'h7F).
- Glyphs: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Simultaneous events:
  - Step press in the same cycle HALTED→RUNNING: the press is dropped.
  - halt asserted on the divider terminal cycle: no pulse.
  - Page and step presses in the same cycle: both act.

## Timing
- All outputs registered.
- Reset values: cpu_enable 0, running 0, channel_sel 0, tick_count 0, hex_out all 1s (blank), FSM HALTED, divider 0, accepted key levels 1, debounce counters 0, synchronisers 1.
- Key latency: with the key held low from clock edge E, the press pulse is internal at E+DEBOUNCE+2. cpu_enable or the channel_sel change is visible after edge E+DEBOUNCE+3.
- Run mode: first cpu_enable DIV cycles after the FSM-entry edge, then exactly every DIV cycles. cpu_enable is never high two consecutive cycles.
- hex_out reflects channel_data/channel_sel one cycle after they change.
- running follows the state register; it rises on the edge after run=1 is sampled.
- Reset mid-operation: everything returns to the reset values on the reset edge, including an in-flight debounce. A key still held low after reset release yields a press DEBOUNCE+3 cycles later.

## Test plan
Parameters for all scenarios: CHANNELS=3, WIDTH=16, DIV=5, DEBOUNCE=4.
- Reset, then step_n low for 20 cycles with 1-cycle glitches beforehand → glitches produce nothing. Exactly one cpu_enable, 7 cycles after the held press starts. tick_count=1.
- run=1 for 22 cycles → running=1, cpu_enable on cycles 5, 10, 15, 20 after entry, tick_count=4. halt=1 on a terminal cycle → no pulse, running=0 next cycle.
- Three page presses → channel_sel 1, 2, 0. With channel data 16'hA5F0 selected: digits 0..3 = 40, 0E, 12, 08. Digits 4..7 = 7F.
- Step press coinciding with HALTED→RUNNING → no extra pulse. Step presses while RUNNING → no extra pulses.
- tick_count preloaded via a force to 32'hFFFFFFFF, one step → 0.
- reset asserted mid-debounce and mid-run → all reset values hold the next cycle. A key held through reset yields a press 7 cycles after reset release.
